// File: rtl/mandelbrot_pkg.sv
// Shared constants and types for the Mandelbrot coordinate generator.
// Coordinates are signed fixed point with FRAC_BITS fractional bits.
package mandelbrot_pkg;

  localparam int WIDTH     = 32;
  localparam int FRAC_BITS = 22;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC_BITS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cg_state_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mandelbrot_coord_gen_if.sv
// Control, parameter and coordinate-stream bundle of the coordinate generator.
// master is the generator side; slave is the sequencer / iteration-stage side.
interface mandelbrot_coord_gen_if #(
  parameter int WIDTH = 32,
  parameter int H_RES = 640,
  parameter int V_RES = 480
);
  import mandelbrot_pkg::*;

  localparam int XW = idx_w(H_RES);
  localparam int YW = idx_w(V_RES);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] x0_real;
  logic [WIDTH-1:0] y0_imag;
  logic [WIDTH-1:0] step;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c_real;
  logic [WIDTH-1:0] c_imag;
  logic [XW-1:0]    pix_x;
  logic [YW-1:0]    pix_y;
  logic             last;
  logic             frame_done;

  modport master (
    input  start, abort, x0_real, y0_imag, step, out_ready,
    output busy, out_valid, c_real, c_imag, pix_x, pix_y, last, frame_done
  );

  modport slave (
    output start, abort, x0_real, y0_imag, step, out_ready,
    input  busy, out_valid, c_real, c_imag, pix_x, pix_y, last, frame_done
  );

endinterface

// File: rtl/mandelbrot_coord_gen.sv
// Raster-order generator of complex c coordinates for a Mandelbrot frame,
// streamed over a valid/ready handshake with fully registered outputs.
//
// state   | meaning
// ST_IDLE | no frame; waiting for start (abort blocks it)
// ST_RUN  | streaming pixels; start ignored, abort cancels
module mandelbrot_coord_gen #(
  parameter int WIDTH = 32,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  mandelbrot_coord_gen_if.master bus
);
  import mandelbrot_pkg::*;

  localparam int XW = idx_w(H_RES);
  localparam int YW = idx_w(V_RES);
  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

  cg_state_t        state_q, state_d;
  logic [WIDTH-1:0] x0_q, x0_d;
  logic [WIDTH-1:0] y0_q, y0_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] cr_q, cr_d;
  logic [WIDTH-1:0] ci_q, ci_d;
  logic [XW-1:0]    px_q, px_d;
  logic [YW-1:0]    py_q, py_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             xfer;

  assign xfer = valid_q && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      step_q  <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      step_q  <= step_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      px_q    <= px_d;
      py_q    <= py_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    step_d  = step_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    px_d    = px_q;
    py_d    = py_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = ST_RUN;
          x0_d    = bus.x0_real;
          y0_d    = bus.y0_imag;
          step_d  = bus.step;
          cr_d    = bus.x0_real;
          ci_d    = bus.y0_imag;
          px_d    = '0;
          py_d    = '0;
          busy_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      ST_RUN: begin
        // abort wins even over a transfer happening in the same cycle
        if (bus.abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end else if (xfer) begin
          if (last_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (px_q == X_MAX) begin
            px_d = '0;
            py_d = py_q + YW'(1);
            cr_d = x0_q;
            ci_d = ci_q - step_q;
          end else begin
            px_d = px_q + XW'(1);
            cr_d = cr_q + step_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // last is registered alongside the position it describes
    last_d = valid_d && (px_d == X_MAX) && (py_d == Y_MAX);
  end

  assign bus.busy       = busy_q;
  assign bus.out_valid  = valid_q;
  assign bus.c_real     = cr_q;
  assign bus.c_imag     = ci_q;
  assign bus.pix_x      = px_q;
  assign bus.pix_y      = py_q;
  assign bus.last       = last_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_mandelbrot_coord_gen.sv
// Self-checking bench for mandelbrot_coord_gen on a 4x3 frame: table-driven
// frames, random frames against a raster model, and directed abort/reset cases.
module tb_mandelbrot_coord_gen;

  localparam int W    = 32;
  localparam int H    = 4;
  localparam int V    = 3;
  localparam int NPIX = H * V;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  logic [W-1:0] cur_x0, cur_y0, cur_step;
  logic [W-1:0] got_cr [NPIX];
  logic [W-1:0] got_ci [NPIX];

  mandelbrot_coord_gen_if #(.WIDTH(W), .H_RES(H), .V_RES(V)) bus ();

  mandelbrot_coord_gen #(.WIDTH(W), .H_RES(H), .V_RES(V)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x0;
    logic [W-1:0] y0;
    logic [W-1:0] st;
    int           mode;
    logic [W-1:0] cr1;
    logic [W-1:0] cr3;
    logic [W-1:0] ci8;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Raster model: pixel k sits at column k%H, row k/H; rows run downward.
  function automatic logic [127:0] exp_beat(input int k);
    logic [W-1:0] cr, ci;
    cr = cur_x0 + W'(k % H) * cur_step;
    ci = cur_y0 - W'(k / H) * cur_step;
    return {57'd0, 1'b1, 1'b1, cr, ci, 2'(k % H), 2'(k / H), (k == NPIX - 1)};
  endfunction

  function automatic logic [127:0] act_beat();
    return {57'd0, bus.out_valid, bus.busy, bus.c_real, bus.c_imag,
            bus.pix_x, bus.pix_y, bus.last};
  endfunction

  function automatic logic [127:0] act_all();
    return {56'd0, bus.busy, bus.out_valid, bus.last, bus.frame_done,
            bus.c_real, bus.c_imag, bus.pix_x, bus.pix_y};
  endfunction

  task automatic kick(input logic [W-1:0] x0, input logic [W-1:0] y0, input logic [W-1:0] st);
    cur_x0   = x0;
    cur_y0   = y0;
    cur_step = st;
    @(negedge clk);
    bus.x0_real   = x0;
    bus.y0_imag   = y0;
    bus.step      = st;
    bus.start     = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_frame(input logic [W-1:0] x0, input logic [W-1:0] y0,
                           input logic [W-1:0] st, input int mode, input int pulse_at);
    int   k;
    int   cyc;
    int   phase;
    logic rdy;
    kick(x0, y0, st);
    k = 0; cyc = 0; phase = 0;
    while (k < NPIX && cyc < 200) begin
      check($sformatf("beat%0d", k), act_beat(), exp_beat(k));
      got_cr[k] = bus.c_real;
      got_ci[k] = bus.c_imag;
      if (k == pulse_at) begin
        bus.start   = 1'b1;
        bus.x0_real = ~x0;
        bus.step    = st + 32'h0001_0000;
      end else begin
        bus.start   = 1'b0;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (phase % 4 == 0) || (phase % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      phase++;
      bus.out_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) k++;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.x0_real   = x0;
    bus.step      = st;
    if (k < NPIX) check("frame_timeout", 128'(k), 128'(NPIX));
    check("done_pulse", {125'd0, bus.frame_done, bus.out_valid, bus.busy}, 128'b100);
    @(negedge clk);
    check("done_single", {126'd0, bus.frame_done, bus.out_valid}, 128'd0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
    bus.x0_real = '0; bus.y0_imag = '0; bus.step = '0;
    cur_x0 = '0; cur_y0 = '0; cur_step = '0;

    vecs[0] = '{32'hFF80_0000, 32'h0040_0000, 32'h0010_0000, 0,
                32'hFF90_0000, 32'hFFB0_0000, 32'h0020_0000};
    vecs[1] = '{32'hFF80_0000, 32'h0040_0000, 32'h0010_0000, 1,
                32'hFF90_0000, 32'hFFB0_0000, 32'h0020_0000};
    vecs[2] = '{32'h7FF0_0000, 32'h0000_0000, 32'h0010_0000, 0,
                32'h8000_0000, 32'h8020_0000, 32'hFFE0_0000};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'hFFF0_0000, 2,
                32'hFFF0_0000, 32'hFFD0_0000, 32'h0020_0000};

    #2;
    check("reset_state", act_all(), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", act_all(), 128'd0);

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].x0, vecs[i].y0, vecs[i].st, vecs[i].mode, -1);
      check($sformatf("vec%0d_cr0", i), 128'(got_cr[0]), 128'(vecs[i].x0));
      check($sformatf("vec%0d_cr1", i), 128'(got_cr[1]), 128'(vecs[i].cr1));
      check($sformatf("vec%0d_cr3", i), 128'(got_cr[3]), 128'(vecs[i].cr3));
      check($sformatf("vec%0d_ci8", i), 128'(got_ci[8]), 128'(vecs[i].ci8));
    end

    for (int i = 0; i < 4; i++)
      run_frame($urandom, $urandom, $urandom, 2, -1);

    // start pulsed mid-frame must not disturb the running frame
    run_frame(32'hFF80_0000, 32'h0040_0000, 32'h0010_0000, 0, 3);

    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_idle", {126'd0, bus.out_valid, bus.busy}, 128'd0);
    @(negedge clk);
    check("start_abort_still_idle", {126'd0, bus.out_valid, bus.busy}, 128'd0);

    // abort at beat 5 with a transfer in the same cycle
    kick(32'hFF80_0000, 32'h0040_0000, 32'h0010_0000);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("abort_beat%0d", k), act_beat(), exp_beat(k));
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    check("abort_beat4", act_beat(), exp_beat(4));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    check("abort_stop", {125'd0, bus.out_valid, bus.busy, bus.frame_done}, 128'd0);
    @(negedge clk);
    check("abort_no_done", {126'd0, bus.frame_done, bus.out_valid}, 128'd0);
    run_frame(32'hFF80_0000, 32'h0040_0000, 32'h0010_0000, 0, -1);

    // reset during row 1
    kick(32'h0030_0000, 32'hFFE0_0000, 32'h0008_0000);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rst_beat%0d", k), act_beat(), exp_beat(k));
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_immediate", act_all(), 128'd0);
    @(negedge clk);
    check("rst_held", act_all(), 128'd0);
    rst = 1'b0;
    run_frame(32'h0010_0000, 32'hFFC0_0000, 32'h0008_0000, 1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
